nios_core_rom_loader: RTL and testbench
=======================================

# nios_core_rom_loader

Boot-image loader sitting directly upstream of the Nios core's dual-port on-chip program memory. It drives that memory's second Avalon slave port (s2). It takes a byte stream from a host link (UART/JTAG bridge), parses a framed image, assembles little-endian 32-bit words and writes them into the 4096-word memory. It holds the CPU in reset until a valid image has been loaded.

## Interface
- ADDR_W, 12, word-address width of target memory
- DEPTH, 4096, memory depth in words; bounds check limit
- MAGIC, 8'hA5, frame start byte

- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader accepts byte; a transfer occurs when in_valid & in_ready
- rearm  in  1  one-cycle pulse; leaves DONE/ERR, returns to IDLE
- address2  out  ADDR_W  memory word address
- writedata2  out  32  memory write data
- byteenable2  out  4  constant 4'hF
- chipselect2  out  1  equals write2
- write2  out  1  one-cycle write strobe
- clken2  out  1  constant 1
- cpu_hold  out  1  CPU reset request; 1 = hold
- busy  out  1  frame in progress (HDR/DATA/CSUM)
- done  out  1  image loaded successfully; sticky
- error  out  1  frame rejected; sticky
- err_code  out  2  0 none, 1 bad header, 2 checksum mismatch

## Operation
- Frame: MAGIC; start address (2 bytes LE); word count (2 bytes LE); count×4 data bytes (LE per word); optional 4-byte LE checksum trailer.
- States: IDLE → HDR → DATA → (CSUM) → DONE; any state with a header fault → ERR.
- IDLE: in_ready=1. Non-MAGIC bytes are discarded. MAGIC → HDR.
- HDR: accepts 4 bytes. After the 4th byte, the header is checked:
  - start ≥ DEPTH, count = 0, or start+count > DEPTH → ERR, err_code=1.
  - Otherwise → DATA, with the address counter set to start.
- DATA: a byte counter (0..3) assembles the word, first byte in [7:0].
  - On the 4th byte: word → writedata2; next cycle write2=chipselect2=1 at address2.
  - The address then increments, and the remaining word count decrements.
  - After the last word → CSUM if configured, else DONE.
- Addresses never wrap; the bounds check guarantees the last address is ≤ DEPTH-1.
- DONE: in_ready=0, done=1, cpu_hold=0, busy=0.
- ERR: in_ready=0, error=1, cpu_hold=1.
- rearm in DONE/ERR → IDLE, clearing done/error/err_code and setting cpu_hold=1. rearm is ignored in other states.
- Running sum: a 32-bit sum of all data words mod 2^32 is accumulated at each word write.

## Timing
- Reset values: cpu_hold=1; in_ready=1; all other outputs 0 except byteenable2=4'hF and clken2=1. State = IDLE, counters 0.
- Reset mid-frame: return to IDLE on the next edge. Words already written stay in memory, and cpu_hold=1.
- in_ready is combinational from state only, never from in_valid. Back-to-back bytes are accepted every cycle in IDLE/HDR/DATA/CSUM.
- Word write latency: write2 pulses exactly 1 cycle after the handshake of the word's 4th byte, for 1 cycle. address2 and writedata2 are stable during the pulse and hold until the next write.
- A write pulse may coincide with acceptance of the next word's 1st byte; the assembly register is separate from writedata2.
- Without checksum: done rises 1 cycle after the final write2 pulse.
- With checksum: done or error rises 1 cycle after the 4th trailer byte handshake.
- Error on header rises 1 cycle after the 4th header byte.
- rearm coinciding with in_valid: rearm wins, and no byte is accepted that cycle (in_ready=0).

## Configuration
- ROM_LOADER_CHECKSUM_EN defined:
  - The CSUM state exists, and the frame carries a 4-byte trailer.
  - Trailer equal to the running sum → DONE.
  - Otherwise → ERR, err_code=2, cpu_hold stays 1. The written data is not erased.
- Undefined:
  - No trailer, no accumulator; DATA → DONE directly.
  - err_code=2 is never produced.

## Test plan
- Basic load: A5, 00 01, 02 00, then 78 56 34 12 EF BE AD DE. Required: write2 at address2=0x100 with data 0x12345678, then at 0x101 with data 0xDEADBEEF; done=1 and cpu_hold=0 one cycle after the second write.
- Bad header: A5, FF 0F, 02 00 (start 4095, count 2). Required: error=1, err_code=1, no write2 pulses, cpu_hold=1. Then rearm → IDLE with error=0.
- Boundary: start 0x000, count 4096 (0x1000), continuous in_valid. Required: 4096 writes, last at address 0xFFF, no wrap; throughput one word per 4 cycles.
- Junk and stall: bytes 00 FF 13 before A5, and in_valid toggled every other cycle. Required: junk dropped; the same writes as the basic load; write2 timing tied to the 4th-byte handshake.
- Checksum (macro defined): basic load plus trailer 67 15 E2 F0 (sum 0xF0E21567) → done=1. Trailer 00 00 00 00 → error=1, err_code=2.
- Reset mid-DATA: reset after 6 data bytes. Required: state IDLE, cpu_hold=1, no further writes. A subsequent full frame loads normally.

Source files
------------

// File: rtl/nios_core_rom_loader.sv
// Boot-image loader: parses a MAGIC-framed byte stream and writes LE words into the Nios program memory (s2 port).
// Optional trailer checksum is enabled by defining ROM_LOADER_CHECKSUM_EN.
module nios_core_rom_loader #(
  parameter int          ADDR_W = 12,
  parameter int          DEPTH  = 4096,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rearm,
  output logic [ADDR_W-1:0] address2,
  output logic [31:0]       writedata2,
  output logic [3:0]        byteenable2,
  output logic              chipselect2,
  output logic              write2,
  output logic              clken2,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  logic [1:0]        hdr_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       hdr_shift;
  logic [23:0]       asm_word;
  logic [ADDR_W-1:0] addr_cnt;
  logic [15:0]       words_left;
  logic              take;
  logic [15:0]       hdr_start;
  logic [15:0]       hdr_count;
  logic [16:0]       hdr_end;
  logic              hdr_bad;
  logic [31:0]       word_in;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [31:0]       run_sum;
`endif

  assign in_ready    = (state == IDLE) || (state == HDR) || (state == DATA) || (state == CSUM);
  assign busy        = (state == HDR) || (state == DATA) || (state == CSUM);
  assign take        = in_valid & in_ready;
  assign byteenable2 = 4'hF;
  assign clken2      = 1'b1;
  assign chipselect2 = write2;

  // Header fields as seen while the 4th header byte is on in_data.
  assign hdr_start = hdr_shift[15:0];
  assign hdr_count = {in_data, hdr_shift[23:16]};
  assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};
  assign hdr_bad   = ({1'b0, hdr_start} >= DEPTH_L) || (hdr_count == 16'd0) || (hdr_end > DEPTH_L);
  assign word_in   = {in_data, asm_word};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hdr_cnt    <= 2'd0;
      byte_cnt   <= 2'd0;
      hdr_shift  <= 24'd0;
      asm_word   <= 24'd0;
      addr_cnt   <= '0;
      words_left <= 16'd0;
      address2   <= '0;
      writedata2 <= 32'd0;
      write2     <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
      run_sum    <= 32'd0;
`endif
    end else begin
      write2 <= 1'b0;
      case (state)
        IDLE: begin
          if (take && (in_data == MAGIC)) begin
            state    <= HDR;
            hdr_cnt  <= 2'd0;
            byte_cnt <= 2'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
            run_sum  <= 32'd0;
`endif
          end
        end
        HDR: begin
          if (take) begin
            hdr_shift <= {in_data, hdr_shift[23:8]};
            hdr_cnt   <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) begin
              if (hdr_bad) begin
                state    <= ERR;
                error    <= 1'b1;
                err_code <= 2'd1;
                cpu_hold <= 1'b1;
              end else begin
                state      <= DATA;
                addr_cnt   <= hdr_start[ADDR_W-1:0];
                words_left <= hdr_count;
                byte_cnt   <= 2'd0;
              end
            end
          end
        end
        DATA: begin
          if (take) begin
            asm_word <= {in_data, asm_word[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              writedata2 <= word_in;
              address2   <= addr_cnt;
              write2     <= 1'b1;
              addr_cnt   <= addr_cnt + 1'b1;
              words_left <= words_left - 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
              run_sum    <= run_sum + word_in;
`endif
              if (words_left == 16'd1) begin
                hdr_cnt <= 2'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
                state   <= CSUM;
`else
                state   <= DONE;
`endif
              end
            end
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        // Trailer reuses the header shift register; the sum is final once DATA leaves.
        CSUM: begin
          if (take) begin
            hdr_shift <= {in_data, hdr_shift[23:8]};
            hdr_cnt   <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) begin
              if ({in_data, hdr_shift} == run_sum) begin
                state    <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state    <= ERR;
                error    <= 1'b1;
                err_code <= 2'd2;
                cpu_hold <= 1'b1;
              end
            end
          end
        end
`endif
        DONE: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          if (rearm) begin
            state    <= IDLE;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            cpu_hold <= 1'b1;
          end
        end
        ERR: begin
          error    <= 1'b1;
          cpu_hold <= 1'b1;
          if (rearm) begin
            state    <= IDLE;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            cpu_hold <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_core_rom_loader.sv
// Scoreboard bench for nios_core_rom_loader: the driver queues expected writes, a monitor checks each write2 pulse.
module tb_nios_core_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rearm;
  logic [11:0] address2;
  logic [31:0] writedata2;
  logic [3:0]  byteenable2;
  logic        chipselect2;
  logic        write2;
  logic        clken2;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  int   cycle = 0;
  int   compared = 0;
  int   failed = 0;
  int   wr_count = 0;
  int   stall_count = 0;
  bit   stall_mode = 0;

  nios_core_rom_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rearm(rearm), .address2(address2), .writedata2(writedata2), .byteenable2(byteenable2),
    .chipselect2(chipselect2), .write2(write2), .clken2(clken2), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Every write pulse must match the oldest queued word, including the cycle it was due.
  always @(negedge clk) begin
    if (write2) begin
      exp_t e;
      compared++;
      wr_count++;
      if (expq.size() == 0) begin
        failed++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", address2, writedata2);
      end else begin
        e = expq.pop_front();
        if (address2 !== e.addr || writedata2 !== e.data || cycle != e.cyc || chipselect2 !== 1'b1) begin
          failed++;
          $display("[TB] FAIL write: got addr 0x%0h data 0x%0h cyc %0d cs %0b, expected addr 0x%0h data 0x%0h cyc %0d cs 1",
                   address2, writedata2, cycle, chipselect2, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one byte from a negedge; returns on the negedge after its handshake.
  task automatic applyStimulus(input logic [7:0] b, input bit push = 1'b0,
                               input logic [11:0] a = 12'd0, input logic [31:0] d = 32'd0);
    int tries = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && tries < 20) begin
      stall_count++;
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      compared++;
      failed++;
      $display("[TB] FAIL handshake: in_ready stayed 0, expected 1 within 20 cycles");
      in_valid = 1'b0;
      return;
    end
    if (push) expq.push_back('{a, d, cycle + 1});
    @(negedge clk);
    in_valid = 1'b0;
    if (stall_mode) @(negedge clk);
  endtask

  task automatic sendHeader(input logic [15:0] start, input logic [15:0] count);
    applyStimulus(8'hA5);
    applyStimulus(start[7:0]);
    applyStimulus(start[15:8]);
    applyStimulus(count[7:0]);
    applyStimulus(count[15:8]);
  endtask

  task automatic sendWord(input logic [11:0] a, input logic [31:0] d);
    applyStimulus(d[7:0]);
    applyStimulus(d[15:8]);
    applyStimulus(d[23:16]);
    applyStimulus(d[31:24], 1'b1, a, d);
  endtask

  task automatic sendTrailer(input logic [31:0] d);
    applyStimulus(d[7:0]);
    applyStimulus(d[15:8]);
    applyStimulus(d[23:16]);
    applyStimulus(d[31:24]);
  endtask

  task automatic doRearm();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  // Basic two-word image at 0x100; checks done timing against the last write.
  task automatic basicLoad(input string tag);
    sendHeader(16'h0100, 16'h0002);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    sendWord(12'h100, 32'h12345678);
    sendWord(12'h101, 32'hDEADBEEF);
`ifdef ROM_LOADER_CHECKSUM_EN
    sendTrailer(32'hF0E21567);
`else
    checkOutput({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
`endif
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    failed++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] sum;
    int          wr0;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; rearm = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_err_code", {30'd0, err_code}, 32'd0);
    checkOutput("rst_write2", {31'd0, write2}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_byteenable2", {28'd0, byteenable2}, 32'hF);
    checkOutput("rst_clken2", {31'd0, clken2}, 32'd1);
    checkOutput("rst_address2", {20'd0, address2}, 32'd0);
    checkOutput("rst_writedata2", writedata2, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    basicLoad("basic");
    doRearm();
    checkOutput("rearm_done", {31'd0, done}, 32'd0);
    checkOutput("rearm_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("rearm_in_ready", {31'd0, in_ready}, 32'd1);

    // Start 4095 with two words runs past the end of memory.
    sendHeader(16'h0FFF, 16'h0002);
    checkOutput("badhdr_error", {31'd0, error}, 32'd1);
    checkOutput("badhdr_err_code", {30'd0, err_code}, 32'd1);
    checkOutput("badhdr_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("badhdr_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    in_data = 8'hA5; in_valid = 1'b1; rearm = 1'b1;
    checkOutput("rearm_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rearm = 1'b0; in_valid = 1'b0;
    checkOutput("badhdr_rearm_error", {31'd0, error}, 32'd0);
    checkOutput("badhdr_rearm_err_code", {30'd0, err_code}, 32'd0);
    checkOutput("rearm_no_byte_taken", {31'd0, busy}, 32'd0);

    sendHeader(16'h0000, 16'h0000);
    checkOutput("count0_err_code", {30'd0, err_code}, 32'd1);
    doRearm();
    sendHeader(16'h1000, 16'h0001);
    checkOutput("start_oob_err_code", {30'd0, err_code}, 32'd1);
    doRearm();

    stall_mode = 1'b1;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h13);
    checkOutput("junk_busy", {31'd0, busy}, 32'd0);
    sendHeader(16'h0100, 16'h0002);
    sendWord(12'h100, 32'h12345678);
    sendWord(12'h101, 32'hDEADBEEF);
`ifdef ROM_LOADER_CHECKSUM_EN
    sendTrailer(32'hF0E21567);
`endif
    stall_mode = 1'b0;
    waitDone("junk_done");
    doRearm();

`ifdef ROM_LOADER_CHECKSUM_EN
    sendHeader(16'h0100, 16'h0002);
    sendWord(12'h100, 32'h12345678);
    sendWord(12'h101, 32'hDEADBEEF);
    sendTrailer(32'h00000000);
    checkOutput("csum_error", {31'd0, error}, 32'd1);
    checkOutput("csum_err_code", {30'd0, err_code}, 32'd2);
    checkOutput("csum_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    doRearm();
`endif

    sendHeader(16'h0200, 16'h0002);
    sendWord(12'h200, 32'h44332211);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (5) @(negedge clk);
    basicLoad("after_rst");
    doRearm();

    // Whole memory, back to back; any in_ready drop would count as a stall.
    stall_count = 0;
    wr0 = wr_count;
    sum = 32'd0;
    sendHeader(16'h0000, 16'h1000);
    for (int i = 0; i < 4096; i++) begin
      logic [31:0] d;
      d = 32'hC0DE0000 | 32'(i);
      sum = sum + d;
      sendWord(12'(i), d);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    sendTrailer(sum);
`endif
    waitDone("full_done");
    checkOutput("full_write_count", 32'(wr_count - wr0), 32'd4096);
    checkOutput("full_stalls", 32'(stall_count), 32'd0);
    checkOutput("full_last_addr", {20'd0, address2}, 32'hFFF);
    checkOutput("full_error", {31'd0, error}, 32'd0);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
